// File: rtl/stereo_window_feeder.sv
// stereo_window_feeder: walks one image row out of the left/right pixel BRAMs.
// For every window start x it loads six left and six right pixels, then sweeps
// disparity d = 0..min(MAX_DISP-1, x). Each step brings in one more right pixel
// on the left side of the right window. Every (window, disparity) pair is
// presented as a valid/ready beat tagged with x, d and a last-disparity flag.
module stereo_window_feeder #(
    parameter int WIDTH    = 320,
    parameter int MAX_DISP = 64,
    parameter int BRAM_LAT = 2,
    localparam int XW      = $clog2(WIDTH),
    localparam int DW      = $clog2(MAX_DISP)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          start_in,
    output logic [XW-1:0] left_addr_out,
    output logic [XW-1:0] right_addr_out,
    input  logic [7:0]    left_pix_in,
    input  logic [7:0]    right_pix_in,
    output logic [47:0]   left_row_out,
    output logic [47:0]   right_row_out,
    output logic [XW-1:0] x_out,
    output logic [DW-1:0] disp_out,
    output logic          last_disp_out,
    output logic          valid_out,
    input  logic          ready_in,
    output logic          busy_out,
    output logic          done_out
);

    // Common width for the x/d arithmetic, so that neither operand is truncated.
    localparam int CW = ((XW > DW) ? XW : DW) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        EMIT  = 2'd2,
        SHIFT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [XW-1:0]       x_q, x_d;
    logic [DW-1:0]       d_q, d_d;
    logic [2:0]          issue_cnt_q, issue_cnt_d;
    logic [2:0]          cap_cnt_q, cap_cnt_d;
    logic [47:0]         left_row_q, left_row_d;
    logic [47:0]         right_row_q, right_row_d;
    logic [XW-1:0]       l_addr_q, l_addr_d;
    logic [XW-1:0]       r_addr_q, r_addr_d;
    // Bit 0 marks a fresh address on the BRAM ports this cycle.
    // Bit BRAM_LAT marks that the read data for it is on pix_in this cycle.
    logic [BRAM_LAT:0]   vld_pipe_q, vld_pipe_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [CW-1:0]       dmax;
    logic                at_dmax;
    logic                x_final;
    logic                cap;
    logic                xfer;
    logic                issue;
    logic [DW-1:0]       d_inc;

    assign dmax    = (CW'(x_q) > CW'(MAX_DISP - 1)) ? CW'(MAX_DISP - 1) : CW'(x_q);
    assign at_dmax = (CW'(d_q) == dmax);
    assign d_inc   = d_q + 1'b1;
    assign x_final = (CW'(x_q) >= CW'(WIDTH - 6));
    assign cap     = vld_pipe_q[BRAM_LAT];
    assign xfer    = valid_q && ready_in;

    // Next-state logic: sequencing, address issue, row capture and beat flags.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        d_d         = d_q;
        issue_cnt_d = issue_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        left_row_d  = left_row_q;
        right_row_d = right_row_q;
        l_addr_d    = l_addr_q;
        r_addr_d    = r_addr_q;
        issue       = 1'b0;
        valid_d     = valid_q;
        last_d      = last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A start that lands in the done cycle is ignored.
                if (start_in && !done_q) begin
                    state_d     = LOAD;
                    x_d         = '0;
                    d_d         = '0;
                    l_addr_d    = '0;
                    r_addr_d    = '0;
                    issue       = 1'b1;
                    issue_cnt_d = 3'd1;
                    cap_cnt_d   = 3'd0;
                    busy_d      = 1'b1;
                end
            end
            LOAD: begin
                // Both ports read the same column, because the right window starts at d=0.
                if (issue_cnt_q != 3'd6) begin
                    l_addr_d    = x_q + XW'(issue_cnt_q);
                    r_addr_d    = x_q + XW'(issue_cnt_q);
                    issue       = 1'b1;
                    issue_cnt_d = issue_cnt_q + 3'd1;
                end
                // Pixels arrive in column order, so they shift in from the bottom byte.
                if (cap) begin
                    left_row_d  = {left_row_q[39:0], left_pix_in};
                    right_row_d = {right_row_q[39:0], right_pix_in};
                    cap_cnt_d   = cap_cnt_q + 3'd1;
                    if (cap_cnt_q == 3'd5) begin
                        state_d = EMIT;
                        valid_d = 1'b1;
                        last_d  = at_dmax;
                    end
                end
            end
            EMIT: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (!at_dmax) begin
                        state_d  = SHIFT;
                        r_addr_d = XW'(CW'(x_q) - CW'(d_q) - CW'(1));
                        issue    = 1'b1;
                    end else if (!x_final) begin
                        state_d     = LOAD;
                        x_d         = x_q + 1'b1;
                        d_d         = '0;
                        l_addr_d    = x_q + 1'b1;
                        r_addr_d    = x_q + 1'b1;
                        issue       = 1'b1;
                        issue_cnt_d = 3'd1;
                        cap_cnt_d   = 3'd0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                // The next column to the left enters at the top byte.
                // The rightmost pixel drops out, and the left row is kept.
                if (cap) begin
                    right_row_d = {right_pix_in, right_row_q[47:8]};
                    d_d         = d_inc;
                    state_d     = EMIT;
                    valid_d     = 1'b1;
                    last_d      = (CW'(d_inc) == dmax);
                end
            end
            default: state_d = IDLE;
        endcase

        vld_pipe_d = {vld_pipe_q[BRAM_LAT-1:0], issue};
    end

    // State and output registers. Reset aborts any sweep in flight.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            x_q         <= '0;
            d_q         <= '0;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            left_row_q  <= '0;
            right_row_q <= '0;
            l_addr_q    <= '0;
            r_addr_q    <= '0;
            vld_pipe_q  <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            d_q         <= d_d;
            issue_cnt_q <= issue_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            left_row_q  <= left_row_d;
            right_row_q <= right_row_d;
            l_addr_q    <= l_addr_d;
            r_addr_q    <= r_addr_d;
            vld_pipe_q  <= vld_pipe_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign left_addr_out  = l_addr_q;
    assign right_addr_out = r_addr_q;
    assign left_row_out   = left_row_q;
    assign right_row_out  = right_row_q;
    assign x_out          = x_q;
    assign disp_out       = d_q;
    assign last_disp_out  = last_q;
    assign valid_out      = valid_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;

endmodule

// File: tb/tb_stereo_window_feeder.sv
// Scoreboard bench for stereo_window_feeder on a 16-pixel row, 4 disparities,
// and a 2-cycle BRAM. The expected beats are derived directly from the window
// and disparity definitions.
module tb_stereo_window_feeder;

    localparam int WIDTH    = 16;
    localparam int MAX_DISP = 4;
    localparam int BRAM_LAT = 2;
    localparam int XW       = $clog2(WIDTH);
    localparam int DW       = $clog2(MAX_DISP);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ready = 1'b0;
    logic [XW-1:0] l_addr, r_addr;
    logic [7:0]    l_pix, r_pix;
    logic [47:0]   l_row, r_row;
    logic [XW-1:0] x_o;
    logic [DW-1:0] d_o;
    logic          last_o, valid_o, busy_o, done_o;

    stereo_window_feeder #(.WIDTH(WIDTH), .MAX_DISP(MAX_DISP), .BRAM_LAT(BRAM_LAT)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start),
        .left_addr_out(l_addr), .right_addr_out(r_addr),
        .left_pix_in(l_pix), .right_pix_in(r_pix),
        .left_row_out(l_row), .right_row_out(r_row),
        .x_out(x_o), .disp_out(d_o), .last_disp_out(last_o),
        .valid_out(valid_o), .ready_in(ready),
        .busy_out(busy_o), .done_out(done_o)
    );

    always #5 clk = ~clk;

    // BRAM model: left mem[i]=i, right mem[i]=0x64+i, with BRAM_LAT register stages.
    logic [XW-1:0] la [BRAM_LAT];
    logic [XW-1:0] ra [BRAM_LAT];
    always @(posedge clk) begin
        la[0] <= l_addr;
        ra[0] <= r_addr;
        for (int i = 1; i < BRAM_LAT; i++) begin
            la[i] <= la[i-1];
            ra[i] <= ra[i-1];
        end
    end
    assign l_pix = 8'(la[BRAM_LAT-1]);
    assign r_pix = 8'(8'h64 + 8'(ra[BRAM_LAT-1]));

    typedef struct {
        int          x;
        int          d;
        logic [47:0] l;
        logic [47:0] r;
        bit          last;
    } beat_t;

    beat_t q[$];
    int n_checks = 0;
    int n_err    = 0;
    int beats    = 0;
    int done_cnt = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] lmem(input int i);
        return 8'(i);
    endfunction
    function automatic logic [7:0] rmem(input int i);
        return 8'(8'h64 + i);
    endfunction

    // Reference model: each window x yields disparities 0..min(MAX_DISP-1, x).
    // The right window for disparity d starts at column x-d.
    task automatic build_expected();
        beat_t b;
        q.delete();
        for (int x = 0; x <= WIDTH - 6; x++) begin
            int dm;
            dm = (x < MAX_DISP - 1) ? x : MAX_DISP - 1;
            for (int d = 0; d <= dm; d++) begin
                b.x = x; b.d = d; b.last = (d == dm);
                b.l = '0; b.r = '0;
                for (int k = 0; k < 6; k++) begin
                    b.l = {b.l[39:0], lmem(x + k)};
                    b.r = {b.r[39:0], rmem(x - d + k)};
                end
                q.push_back(b);
            end
        end
    endtask

    // Monitor: pops one expected beat per transfer.
    // It also checks that a stalled beat and the addresses hold steady.
    logic         stalled = 1'b0;
    logic [127:0] snap;
    logic         busy_chk = 1'b0;
    always @(negedge clk) begin
        logic [127:0] cur;
        beat_t e;
        cur = {l_row, r_row, x_o, d_o, last_o, l_addr, r_addr};
        if (busy_chk) begin
            chk("busy_after_done", busy_o, 0);
            busy_chk = 1'b0;
        end
        if (rst_n && valid_o) begin
            if (stalled) chk("stall_hold", cur, snap);
            if (ready) begin
                stalled = 1'b0;
                if (q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("beat_x", x_o, e.x);
                    chk("beat_d", d_o, e.d);
                    chk("beat_left", l_row, e.l);
                    chk("beat_right", r_row, e.r);
                    chk("beat_last", last_o, e.last);
                end
                beats++;
            end else begin
                stalled = 1'b1;
                snap = cur;
            end
        end else begin
            stalled = 1'b0;
        end
        if (rst_n && done_o) begin
            done_cnt++;
            chk("done_all_beats", q.size(), 0);
            busy_chk = 1'b1;
        end
    end

    // mode 0: ready held high. mode 1: random ready with a forced 5-cycle stall,
    // plus start pulses while busy. abort_at > 0: reset once that many beats are seen.
    task automatic run_row(input int mode, input int abort_at);
        int  cyc;
        bit  aborted;
        build_expected();
        beats = 0; done_cnt = 0; aborted = 0;
        ready = (mode == 0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (mode == 0) begin
            cyc = 0;
            while (!valid_o && cyc < 50) begin
                @(posedge clk); #1 cyc++;
            end
            chk("first_valid_latency", cyc, 6 + BRAM_LAT);
        end
        cyc = 0;
        while (!done_o && cyc < 3000) begin
            if (abort_at > 0 && beats >= abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_outputs_zero",
                    {valid_o, busy_o, done_o, last_o, l_row, r_row, x_o, d_o, l_addr, r_addr}, 0);
                aborted = 1;
                break;
            end
            if (mode == 1) begin
                ready = (cyc >= 30 && cyc < 35) ? 1'b0 : ($urandom_range(3) != 0);
                start = busy_o && ($urandom_range(7) == 0);
            end
            @(posedge clk); #1 cyc++;
        end
        start = 1'b0;
        if (aborted) begin
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            chk("abort_no_done", done_cnt, 0);
            chk("abort_idle", {valid_o, busy_o}, 0);
            q.delete();
        end else begin
            chk("row_finished", done_o, 1);
            repeat (3) @(posedge clk);
            #1;
            chk("beat_count", beats, 38);
            chk("done_once", done_cnt, 1);
        end
    endtask

    initial begin
        #12;
        chk("reset_outputs_zero",
            {valid_o, busy_o, done_o, last_o, l_row, r_row, x_o, d_o, l_addr, r_addr}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run_row(0, 0);
        run_row(1, 0);
        run_row(0, 10);
        run_row(0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
